train_sched: RTL

TRAIN_SCHED -- requirements
Module: train_sched

---
 rtl/train_sched.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/train_sched.sv
// Training scheduler: buffers encoded samples and sequences training and override-load
// operations into the class memory, keeping per-class sample counts.
module train_sched #(
  parameter int DIMENSIONS = 6,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  parameter int TIMEOUT    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIMENSIONS-1:0] in_hv,
  input  logic                  in_label,
  input  logic                  ovr_req,
  input  logic [DIMENSIONS-1:0] ovr_hv_nonseizure,
  input  logic [DIMENSIONS-1:0] ovr_hv_seizure,
  output logic                  cm_en,
  output logic                  cm_label_override,
  output logic [DIMENSIONS-1:0] cm_override_hv_nonseizure,
  output logic [DIMENSIONS-1:0] cm_override_hv_seizure,
  output logic [DIMENSIONS-1:0] cm_hv_train,
  output logic                  cm_label,
  input  logic                  cm_done,
  output logic                  busy,
  output logic [CNT_W-1:0]      cnt_nonseizure,
  output logic [CNT_W-1:0]      cnt_seizure,
  output logic                  timeout_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_OVR_ISSUE, S_OVR_WAIT, S_ISSUE, S_WAIT} state_t;

  state_t                r_state, w_state_nxt;
  logic [DIMENSIONS-1:0] r_fifo_hv [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_lbl;
  logic [AW:0]           r_wr_ptr, r_rd_ptr;
  logic                  r_ovr_pending;
  logic [DIMENSIONS-1:0] r_ovr_ns, r_ovr_s, r_hv_train;
  logic                  r_label;
  logic [CNT_W-1:0]      r_cnt_ns, r_cnt_s;
  logic                  r_timeout_err;
  logic [TW-1:0]         r_wait_cnt;

  logic w_empty, w_full, w_push, w_pop, w_load, w_ovr_clr;
  logic w_cnt_inc, w_cnt_clr, w_timeout, w_tmo_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign in_ready  = !w_full;
  assign w_push    = in_valid && !w_full;
  assign w_pop     = (r_state == S_ISSUE);
  assign w_tmo_hit = (r_wait_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt       = r_state;
    cm_en             = 1'b0;
    cm_label_override = 1'b0;
    w_load            = 1'b0;
    w_ovr_clr         = 1'b0;
    w_cnt_inc         = 1'b0;
    w_cnt_clr         = 1'b0;
    w_timeout         = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_ovr_pending) begin
          w_state_nxt = S_OVR_ISSUE;
        end else if (!w_empty) begin
          w_state_nxt = S_ISSUE;
          w_load      = 1'b1;
        end
      end
      S_OVR_ISSUE: begin
        cm_en             = 1'b1;
        cm_label_override = 1'b1;
        w_ovr_clr         = 1'b1;
        w_state_nxt       = S_OVR_WAIT;
      end
      S_OVR_WAIT: begin
        cm_label_override = 1'b1;
        if (cm_done) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_tmo_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_ISSUE: begin
        cm_en       = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cm_done) begin
          w_cnt_inc   = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_tmo_hit) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Sample storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_hv[r_wr_ptr[AW-1:0]]  <= in_hv;
      r_fifo_lbl[r_wr_ptr[AW-1:0]] <= in_label;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_ovr_pending <= 1'b0;
      r_ovr_ns      <= '0;
      r_ovr_s       <= '0;
      r_hv_train    <= '0;
      r_label       <= 1'b0;
      r_cnt_ns      <= '0;
      r_cnt_s       <= '0;
      r_timeout_err <= 1'b0;
      r_wait_cnt    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
      // A fresh request wins over the clear issued by OVR_ISSUE in the same cycle.
      if (ovr_req) begin
        r_ovr_pending <= 1'b1;
        r_ovr_ns      <= ovr_hv_nonseizure;
        r_ovr_s       <= ovr_hv_seizure;
      end else if (w_ovr_clr) begin
        r_ovr_pending <= 1'b0;
      end
      if (w_load) begin
        r_hv_train <= r_fifo_hv[r_rd_ptr[AW-1:0]];
        r_label    <= r_fifo_lbl[r_rd_ptr[AW-1:0]];
      end
      if (r_state == S_ISSUE || r_state == S_OVR_ISSUE) r_wait_cnt <= '0;
      else if (r_state == S_WAIT || r_state == S_OVR_WAIT) r_wait_cnt <= r_wait_cnt + TW'(1);
      if (w_cnt_clr) begin
        r_cnt_ns <= '0;
        r_cnt_s  <= '0;
      end else if (w_cnt_inc) begin
        if (r_label) r_cnt_s  <= sat_inc(r_cnt_s);
        else         r_cnt_ns <= sat_inc(r_cnt_ns);
      end
      if (w_timeout) r_timeout_err <= 1'b1;
    end
  end

  assign cm_override_hv_nonseizure = r_ovr_ns;
  assign cm_override_hv_seizure    = r_ovr_s;
  assign cm_hv_train               = r_hv_train;
  assign cm_label                  = r_label;
  assign cnt_nonseizure            = r_cnt_ns;
  assign cnt_seizure               = r_cnt_s;
  assign timeout_err               = r_timeout_err;
  assign busy = (r_state != S_IDLE) || !w_empty || r_ovr_pending;

endmodule
